countdown_wrap_alarm: RTL
=========================

# countdown_wrap_alarm

Downstream monitor for the 4-bit free-running down counter. Samples the counter's `count` bus every clock and detects wrap-around (0 followed by all-ones). It counts wraps while armed and raises a held alarm once a programmable number of wraps has elapsed. The alarm stays high until software or a controller acknowledges it, which turns the bare counter into a coarse countdown timer with a handshake.

## Interface
- `WIDTH`, 4: width of the monitored count bus.
- `WRAP_LIMIT`, 3: wraps counted in ARMED before the alarm fires. Legal range 1..255.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: reset, synchronous, active-high.
- `count_in  in  WIDTH`: count value from the upstream down counter.
- `arm  in  1`: level. Sampled in IDLE; requests IDLE→ARMED.
- `ack  in  1`: level. Sampled in ARMED (abort) and ALARM (acknowledge).
- `wrap_pulse  out  1`: one-cycle strobe per detected wrap, in any state.
- `wrap_cnt  out  8`: wraps counted since the last arm. Saturates at 255.
- `alarm  out  1`: high exactly while the state is ALARM.
- `state  out  2`: IDLE=0, ARMED=1, ALARM=2. Encoding 3 is unreachable.

## Operation
- Detector:
  - A `prev` register captures `count_in` every cycle.
  - A `prev_valid` flag clears on reset and sets after the first post-reset sample.
  - A wrap is `prev_valid && prev == 0 && count_in == {WIDTH{1'b1}}`.
  - All other transitions (0→0, 0→5, stalls, upward jumps) are not wraps.
- FSM:
  - IDLE:
    - arm=1 → ARMED, clearing `wrap_cnt` to 0 on the same edge.
    - ack is ignored. If arm and ack are both high, arm wins.
  - ARMED:
    - Each wrap increments `wrap_cnt`.
    - If the incremented value equals WRAP_LIMIT, go to ALARM on that edge.
    - ack=1 → IDLE (abort), `wrap_cnt` holds. If ack and a wrap coincide, ack wins and the wrap is not counted.
  - ALARM:
    - Wraps keep incrementing `wrap_cnt`, saturating.
    - ack=1 → IDLE, `wrap_cnt` holds. If ack and a wrap coincide, ack wins and the wrap is not counted.
    - arm is ignored.
- `wrap_cnt` does not change in IDLE, except for the clear on arm.
- `wrap_pulse` is independent of the FSM. Its behaviour is identical in all states, including the ack cycle.

## Timing
- All outputs are registered. No combinational input→output paths.
- Reset (rst high at a rising edge) sets:
  - `state`=IDLE, `alarm`=0, `wrap_pulse`=0, `wrap_cnt`=0
  - `prev`=0, `prev_valid`=0
- Reset overrides every other input, including mid-ALARM.
- Wrap latency: let edge k be the first edge sampling all-ones, with edge k-1 having sampled 0.
  - `wrap_pulse` is high in the cycle after edge k, for one cycle only.
  - `wrap_cnt` updates at edge k.
  - If the limit is reached, `alarm` rises at edge k, in the same cycle as `wrap_pulse`.
- The first sample after reset can never produce a wrap, even if `count_in` is all-ones.
- arm/ack: the state change takes effect on the same edge that samples the input. Latency is 1 cycle.
- With a 4-bit upstream counter free-running from reset, wraps occur every 16 cycles.

## Test plan
- Reset: hold rst for 2 cycles with arbitrary inputs → all outputs 0 and state=0. Release with count_in=15 → no wrap_pulse.
- Detector in IDLE: drive count_in 2,1,0,15 → wrap_pulse high for exactly one cycle, `wrap_cnt` stays 0, state stays 0.
- Non-wraps: drive 0,0,5,15 and 1,15 → wrap_pulse never asserts.
- Full countdown, WRAP_LIMIT=3:
  - Pulse arm for 1 cycle, with the upstream down counter free-running.
  - `alarm` rises in the same cycle as the 3rd wrap_pulse, with `wrap_cnt`=3.
  - `alarm` stays high through the 4th wrap, with `wrap_cnt`=4.
  - Pulse ack → state=0 and `alarm`=0 after the edge, `wrap_cnt` holds at 4.
- Simultaneous events:
  - In ALARM, ack coincides with a wrap → state=IDLE, `wrap_cnt` unchanged, wrap_pulse still asserts.
  - In IDLE, arm and ack together → ARMED with `wrap_cnt`=0.
- Reset mid-operation: assert rst while in ALARM with `wrap_cnt`=3 → next cycle all outputs 0, and the next 0→15 transition immediately after rst release gives no pulse.

Source files
------------

// File: rtl/countdown_wrap_alarm.sv
// Wrap monitor for a free-running down counter: detects 0 -> all-ones,
// counts wraps while armed and holds an alarm until acknowledged.
module countdown_wrap_alarm #(
    parameter int WIDTH      = 4,
    parameter int WRAP_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic             arm,
    input  logic             ack,
    output logic             wrap_pulse,
    output logic [7:0]       wrap_cnt,
    output logic             alarm,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ALARM = 2'd2
    } state_t;

    localparam logic [7:0] LIMIT = 8'(WRAP_LIMIT);

    state_t           st_q;
    state_t           st_d;
    logic [7:0]       cnt_d;
    logic [7:0]       cnt_inc;
    logic [WIDTH-1:0] prev;
    logic             prev_valid;
    logic             wrap;

    assign wrap    = prev_valid && (prev == '0) && (count_in == {WIDTH{1'b1}});
    assign cnt_inc = (wrap_cnt == 8'hFF) ? 8'hFF : wrap_cnt + 8'd1;

    always_comb begin
        st_d  = st_q;
        cnt_d = wrap_cnt;
        unique case (st_q)
            IDLE: begin
                if (arm) begin
                    st_d  = ARMED;
                    cnt_d = 8'd0;
                end
            end
            ARMED: begin
                // ack takes priority; a coincident wrap is dropped
                if (ack) begin
                    st_d = IDLE;
                end else if (wrap) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == LIMIT) st_d = ALARM;
                end
            end
            ALARM: begin
                if (ack) begin
                    st_d = IDLE;
                end else if (wrap) begin
                    cnt_d = cnt_inc;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= IDLE;
            wrap_cnt   <= 8'd0;
            wrap_pulse <= 1'b0;
            prev       <= '0;
            prev_valid <= 1'b0;
        end else begin
            st_q       <= st_d;
            wrap_cnt   <= cnt_d;
            wrap_pulse <= wrap;
            prev       <= count_in;
            prev_valid <= 1'b1;
        end
    end

    assign alarm = (st_q == ALARM);
    assign state = st_q;

endmodule
